// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the program counter, issues imem req/ack
// fetches, and parks a redirect that lands mid-request until the ack retires it.
//
//   state | meaning
//   BOOT  | one cycle after reset before the first fetch
//   REQ   | fetch outstanding at pc_q (imem_req=1)
//   HOLD  | instruction held for a stalled consumer, no fetch
//   HALT  | fetching stopped until resume
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    logic        redir_ok;
    logic        redir_bad;
    logic [31:0] pc_seq;
    state_t      boundary_state;

    assign redir_bad      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_ok       = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign pc_seq         = pc_q + STEP;
    assign boundary_state = halt ? HALT : REQ;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        // A held instruction is consumed whenever the consumer is not stalled.
        inst_valid_d = inst_valid_q && stall;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        misalign_d   = redir_bad;

        case (state_q)
            BOOT: begin
                if (redir_ok) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else begin
                    state_d = boundary_state;
                end
            end

            REQ: begin
                if (imem_ack && (redir_ok || pend_valid_q)) begin
                    // Returned word belongs to the stale stream; the newest target wins.
                    pc_d         = redir_ok ? redirect_pc : pend_pc_q;
                    pend_valid_d = 1'b0;
                    if (redir_ok) begin
                        inst_valid_d = 1'b0;
                    end
                    state_d = boundary_state;
                end else if (redir_ok) begin
                    // Address must stay stable until the ack, so park the target.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                    inst_valid_d = 1'b0;
                end else if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_seq;
                    if (halt) begin
                        state_d = HALT;
                    end else if (stall) begin
                        state_d = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end

            HOLD: begin
                if (redir_ok) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end else if (halt) begin
                    state_d = HALT;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end

            HALT: begin
                if (redir_ok) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                end else if (!halt && resume) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed fetch scenarios with fixed
// expectations, then a long randomized run against a rule-level reference model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        misalign_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_3000), .STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .resume(resume),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .pc(pc), .misalign_err(misalign_err)
    );

    // Reference model: fetcher described by what it is doing, not by an encoding.
    typedef enum int {M_BOOT, M_FETCH, M_WAIT_CONSUMER, M_STOPPED} mode_t;
    mode_t       m_mode  = M_BOOT;
    bit [31:0]   m_pc    = 32'h3000;
    bit          m_valid = 1'b0;
    bit [31:0]   m_inst  = 32'h0;
    bit [31:0]   m_ipc   = 32'h0;
    bit          m_mis   = 1'b0;
    bit [31:0]   m_pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic model_step();
        bit good;
        bit bad;
        if (rst) begin
            m_mode = M_BOOT; m_pc = 32'h3000; m_pend.delete();
            m_valid = 1'b0; m_inst = 32'h0; m_ipc = 32'h0; m_mis = 1'b0;
        end else begin
            bad   = redirect_valid && (redirect_pc[1:0] != 2'b00);
            good  = redirect_valid && !bad;
            m_mis = bad;
            if (m_valid && !stall) m_valid = 1'b0;
            if (good) begin
                m_valid = 1'b0;
                if (m_mode == M_FETCH && !imem_ack) begin
                    m_pend.delete();
                    m_pend.push_back(redirect_pc);
                end else begin
                    m_pc = redirect_pc;
                    m_pend.delete();
                    if (m_mode == M_FETCH) m_mode = halt ? M_STOPPED : M_FETCH;
                    else if (m_mode != M_STOPPED) m_mode = M_FETCH;
                end
            end else if (m_mode == M_FETCH && imem_ack) begin
                if (m_pend.size() != 0) begin
                    m_pc = m_pend[m_pend.size() - 1];
                    m_pend.delete();
                    m_mode = halt ? M_STOPPED : M_FETCH;
                end else begin
                    m_inst  = imem_rdata;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                    m_mode  = halt ? M_STOPPED : (stall ? M_WAIT_CONSUMER : M_FETCH);
                end
            end else if (m_mode == M_BOOT) begin
                m_mode = halt ? M_STOPPED : M_FETCH;
            end else if (m_mode == M_WAIT_CONSUMER) begin
                if (halt) m_mode = M_STOPPED;
                else if (!stall) m_mode = M_FETCH;
            end else if (m_mode == M_STOPPED) begin
                if (!halt && resume) m_mode = M_FETCH;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then settle past the edge.
    task automatic cyc(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                       input bit h, input bit rs, input bit ack);
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
        halt = h; resume = rs; imem_ack = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (pc !== 32'h3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); else n_pass++;
        n_total++; if (imem_addr !== 32'h3000) $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h3000); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid); else n_pass++;
        n_total++; if (inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst); else n_pass++;
        n_total++; if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); else n_pass++;
        n_total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign_err); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("FAIL seq_first_req got req=%b addr=%h exp req=1 addr=3000", imem_req, imem_addr); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            a = 32'h3000 + 32'(4 * k);
            cyc(0, 0, 0, 0, 0, 0, 1);
            n_total++; if (inst_valid !== 1'b1 || inst_pc !== a)
                $display("FAIL seq_inst_pc got valid=%b pc=%h exp valid=1 pc=%h", inst_valid, inst_pc, a); else n_pass++;
            n_total++; if (inst !== mem_word(a))
                $display("FAIL seq_inst got=%h exp=%h", inst, mem_word(a)); else n_pass++;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== a + 32'd4)
                $display("FAIL seq_addr got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, a + 32'd4); else n_pass++;
        end
        n_total++; if (pc !== 32'h300C) $display("FAIL seq_pc got=%h exp=%h", pc, 32'h300C); else n_pass++;
    endtask

    task automatic test_redirect_pending();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h4000, 0, 0, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("FAIL pend_addr_hold1 got req=%b addr=%h exp req=1 addr=3000", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (imem_addr !== 32'h3000) $display("FAIL pend_addr_hold2 got=%h exp=3000", imem_addr); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1);
        n_total++; if (inst_valid !== 1'b0) $display("FAIL pend_discard got valid=%b exp=0", inst_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000)
            $display("FAIL pend_target got req=%b addr=%h exp req=1 addr=4000", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_stall_hold();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        n_total++; if (imem_req !== 1'b0 || pc !== 32'h3008)
            $display("FAIL hold_enter got req=%b pc=%h exp req=0 pc=3008", imem_req, pc); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            n_total++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h3004)
                $display("FAIL hold_keep got req=%b valid=%b inst_pc=%h exp req=0 valid=1 inst_pc=3004",
                         imem_req, inst_valid, inst_pc); else n_pass++;
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || inst_valid !== 1'b0)
            $display("FAIL hold_exit got req=%b addr=%h valid=%b exp req=1 addr=3008 valid=0",
                     imem_req, imem_addr, inst_valid); else n_pass++;
    endtask

    task automatic test_misalign();
        cyc(0, 0, 1, 32'h5002, 0, 0, 0);
        n_total++; if (misalign_err !== 1'b1 || pc !== 32'h3008)
            $display("FAIL mis_pulse got err=%b pc=%h exp err=1 pc=3008", misalign_err, pc); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1);
        n_total++; if (misalign_err !== 1'b0) $display("FAIL mis_clear got=%b exp=0", misalign_err); else n_pass++;
        n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3008 || pc !== 32'h300C)
            $display("FAIL mis_continue got valid=%b inst_pc=%h pc=%h exp valid=1 inst_pc=3008 pc=300c",
                     inst_valid, inst_pc, pc); else n_pass++;
    endtask

    task automatic test_halt();
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010)
            $display("FAIL halt_waits got req=%b addr=%h exp req=1 addr=3010", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 0, 1, 0, 1);
        n_total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3010 || pc !== 32'h3014 || imem_req !== 1'b0)
            $display("FAIL halt_capture got valid=%b inst_pc=%h pc=%h req=%b exp 1/3010/3014/0",
                     inst_valid, inst_pc, pc, imem_req); else n_pass++;
        cyc(0, 0, 0, 0, 1, 1, 0);
        n_total++; if (imem_req !== 1'b0) $display("FAIL halt_wins got req=%b exp=0", imem_req); else n_pass++;
        cyc(0, 0, 0, 0, 0, 1, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3014)
            $display("FAIL halt_resume got req=%b addr=%h exp req=1 addr=3014", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
        n_total++; if (pc !== 32'hFFFF_FFFC || inst_valid !== 1'b0)
            $display("FAIL wrap_redirect got pc=%h valid=%b exp pc=fffffffc valid=0", pc, inst_valid); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1);
        n_total++; if (pc !== 32'h0 || inst_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_pc got pc=%h inst_pc=%h exp pc=0 inst_pc=fffffffc", pc, inst_pc); else n_pass++;
        cyc(0, 1, 0, 0, 0, 0, 0);
        n_total++; if (imem_req !== 1'b1 || inst_valid !== 1'b1)
            $display("FAIL rst_pre got req=%b valid=%b exp req=1 valid=1", imem_req, inst_valid); else n_pass++;
        cyc(1, 1, 0, 0, 0, 0, 0);
        n_total++; if (pc !== 32'h3000 || inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_pc !== 32'h0)
            $display("FAIL rst_mid got pc=%h valid=%b req=%b inst_pc=%h exp 3000/0/0/0",
                     pc, inst_valid, imem_req, inst_pc); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
            $display("FAIL rst_boot got req=%b addr=%h exp req=1 addr=3000", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_random();
        bit          r, st, rv, h, rs, ack, fast;
        logic [31:0] rpc;
        cyc(1, 0, 0, 0, 0, 0, 0);
        fast = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 250) == 0) fast = ~fast;
            r   = ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            h   = ($urandom_range(0, 11) == 0);
            rs  = ($urandom_range(0, 3) == 0);
            ack = (m_mode == M_FETCH) && (fast || $urandom_range(0, 2) == 0);
            cyc(r, st, rv, rpc, h, rs, ack);
            n_total++; if (imem_req !== (m_mode == M_FETCH))
                $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, (m_mode == M_FETCH)); else n_pass++;
            n_total++; if (pc !== m_pc || imem_addr !== m_pc)
                $display("FAIL rnd_pc cyc=%0d got pc=%h addr=%h exp=%h", i, pc, imem_addr, m_pc); else n_pass++;
            n_total++; if (inst_valid !== m_valid)
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, inst_valid, m_valid); else n_pass++;
            n_total++; if (inst !== m_inst || inst_pc !== m_ipc)
                $display("FAIL rnd_inst cyc=%0d got inst=%h pc=%h exp inst=%h pc=%h", i, inst, inst_pc, m_inst, m_ipc); else n_pass++;
            n_total++; if (misalign_err !== m_mis)
                $display("FAIL rnd_misalign cyc=%0d got=%b exp=%b", i, misalign_err, m_mis); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_pending();
        test_stall_hold();
        test_misalign();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
